// File: rtl/cpu_pkg.sv
// Shared core types: register-file geometry, writeback source encoding.
// Define WB_R0_ZERO_EN to make register 0 a hardwired zero.
package cpu_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;
  localparam int CNT_W    = 2;

`ifdef WB_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } wb_src_t;

  // Round-robin: the source not granted last time wins a tie.
  function automatic wb_src_t rr_next(input wb_src_t last);
    return (last == SRC_ALU) ? SRC_LD : SRC_ALU;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write counters; drives busy and issue_ready.
// Ports: issue_valid/issue_reg/issue_ready (decode), commit_en/commit_reg
// (regfile write this cycle), busy (bit r = r has pending writes).
// WB_R0_ZERO_EN: issues to r0 are never counted.
module wb_scoreboard #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int CNT_W  = cpu_pkg::CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic [ADDR_W-1:0]      issue_reg,
  output logic                   issue_ready,
  input  logic                   commit_en,
  input  logic [ADDR_W-1:0]      commit_reg,
  output logic [(1<<ADDR_W)-1:0] busy
);

  localparam int NR = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NR];
  logic [CNT_W-1:0] cnt_d [NR];
  logic             inc_ok;

  always_comb begin
    // A full counter can still accept when its register commits this edge.
    issue_ready = !((cnt_q[issue_reg] == CNT_MAX) &&
                    !(commit_en && (commit_reg == issue_reg)));
    inc_ok = issue_valid && issue_ready &&
             !(cpu_pkg::R0_ZERO && (issue_reg == '0));
    for (int r = 0; r < NR; r++) begin
      cnt_d[r] = cnt_q[r];
      if (inc_ok && (issue_reg == ADDR_W'(r)))
        cnt_d[r] = cnt_d[r] + CNT_W'(1);
      // Spurious commit on an idle register leaves it at zero.
      if (commit_en && (commit_reg == ADDR_W'(r)) && (cnt_q[r] != '0))
        cnt_d[r] = cnt_d[r] - CNT_W'(1);
      busy[r] = (cnt_q[r] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NR; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NR; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  always @(posedge clk) begin
    if (!rst && commit_en)
      assert (cnt_q[commit_reg] != '0)
        else $error("wb_scoreboard: commit to r%0d with none pending",
                    commit_reg);
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and load results onto the regfile port.
// Ports: issue_* (decode), alu_*/ld_* (result handshakes), write_en/wreg/
// writedata (regfile), busy (RAW scoreboard). WB_R0_ZERO_EN: r0 is zero.
module wb_arbiter #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int CNT_W  = cpu_pkg::CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic [ADDR_W-1:0]      issue_reg,
  output logic                   issue_ready,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [ADDR_W-1:0]      alu_reg,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [ADDR_W-1:0]      ld_reg,
  input  logic [DATA_W-1:0]      ld_data,
  output logic                   write_en,
  output logic [ADDR_W-1:0]      wreg,
  output logic [DATA_W-1:0]      writedata,
  output logic [(1<<ADDR_W)-1:0] busy
);

  cpu_pkg::wb_src_t last_q, last_d, win;

  logic              alu_xfer, ld_xfer, wr_ok;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  always_comb begin
    win       = cpu_pkg::rr_next(last_q);
    alu_ready = 1'b1;
    ld_ready  = 1'b1;
    if (alu_valid && ld_valid) begin
      alu_ready = (win == cpu_pkg::SRC_ALU);
      ld_ready  = (win == cpu_pkg::SRC_LD);
    end
    alu_xfer = alu_valid && alu_ready;
    ld_xfer  = ld_valid && ld_ready;

    sel_reg  = alu_reg;
    sel_data = alu_data;
    last_d   = last_q;
    unique case (1'b1)
      alu_xfer: last_d = cpu_pkg::SRC_ALU;
      ld_xfer: begin
        sel_reg  = ld_reg;
        sel_data = ld_data;
        last_d   = cpu_pkg::SRC_LD;
      end
      default: ;
    endcase

    // r0 results still handshake but never reach the regfile.
    wr_ok   = (alu_xfer || ld_xfer) &&
              !(cpu_pkg::R0_ZERO && (sel_reg == '0));
    we_d    = wr_ok;
    wreg_d  = wr_ok ? sel_reg : wreg_q;
    wdata_d = wr_ok ? sel_data : wdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q  <= cpu_pkg::SRC_ALU;
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      last_q  <= last_d;
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

  assign write_en  = we_q;
  assign wreg      = wreg_q;
  assign writedata = wdata_q;

  wb_scoreboard #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .issue_ready (issue_ready),
    .commit_en   (we_q),
    .commit_reg  (wreg_q),
    .busy        (busy)
  );

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus a randomized run
// checked against a counting reference model.
module tb_wb_arbiter;

`ifdef WB_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic [2:0]  issue_reg = '0;
  logic        issue_ready;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [2:0]  alu_reg = '0;
  logic [15:0] alu_data = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [2:0]  ld_reg = '0;
  logic [15:0] ld_data = '0;
  logic        write_en;
  logic [2:0]  wreg;
  logic [15:0] writedata;
  logic [7:0]  busy;

  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .issue_ready(issue_ready),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_reg(alu_reg), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_reg(ld_reg), .ld_data(ld_data),
    .write_en(write_en), .wreg(wreg), .writedata(writedata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pending counts, last winner, expected output stage.
  int   m_cnt [8];
  bit   m_last_alu;
  bit   m_we;
  int   m_wr;
  int   m_wd;
  bit   e_ir, e_ar, e_lr;
  logic [7:0] e_busy;

  task automatic model_reset;
    for (int r = 0; r < 8; r++) m_cnt[r] = 0;
    m_last_alu = 1'b1;
    m_we = 1'b0;
    m_wr = 0;
    m_wd = 0;
  endtask

  task automatic model_comb;
    e_ar = 1'b1;
    e_lr = 1'b1;
    if (alu_valid && ld_valid) begin
      e_ar = !m_last_alu;
      e_lr = m_last_alu;
    end
    e_ir = !(m_cnt[issue_reg] == 3 &&
             !(m_we && m_wr == int'(issue_reg)));
    for (int r = 0; r < 8; r++) e_busy[r] = (m_cnt[r] != 0);
  endtask

  task automatic tick;
    bit ax, lx, inc;
    int ir, nr, nd;
    model_comb;
    ax  = alu_valid && e_ar;
    lx  = ld_valid && e_lr;
    ir  = int'(issue_reg);
    inc = issue_valid && e_ir && !(R0Z && ir == 0);
    nr  = ax ? int'(alu_reg) : int'(ld_reg);
    nd  = ax ? int'(alu_data) : int'(ld_data);
    @(posedge clk);
    if (m_we && m_cnt[m_wr] > 0) m_cnt[m_wr]--;
    if (inc) m_cnt[ir]++;
    if (ax || lx) begin
      m_last_alu = ax;
      m_we = !(R0Z && nr == 0);
      if (m_we) begin
        m_wr = nr;
        m_wd = nd;
      end
    end else begin
      m_we = 1'b0;
    end
    #1;
  endtask

  task automatic idle_inputs;
    issue_valid = 1'b0;
    alu_valid = 1'b0;
    ld_valid = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset;
  endtask

  task automatic test_reset;
    #1;
    vectors++;
    if (write_en !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_we got=%b want=0", write_en);
    end
    vectors++;
    if (wreg !== 3'd0 || writedata !== 16'h0) begin
      miscompares++;
      $display("FAIL rst_out got=%0d/%h want=0/0", wreg, writedata);
    end
    vectors++;
    if (busy !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_busy got=%h want=00", busy);
    end
    vectors++;
    if ({issue_ready, alu_ready, ld_ready} !== 3'b111) begin
      miscompares++;
      $display("FAIL rst_ready got=%b want=111",
               {issue_ready, alu_ready, ld_ready});
    end
  endtask

  task automatic test_alu_only;
    issue_valid = 1'b1;
    issue_reg = 3'd3;
    tick;
    issue_valid = 1'b0;
    alu_valid = 1'b1;
    alu_reg = 3'd3;
    alu_data = 16'h1234;
    #1;
    vectors++;
    if (alu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL alu_ready got=%b want=1", alu_ready);
    end
    tick;
    alu_valid = 1'b0;
    #1;
    vectors++;
    if (write_en !== 1'b1 || wreg !== 3'd3 || writedata !== 16'h1234) begin
      miscompares++;
      $display("FAIL alu_write got=%b/%0d/%h want=1/3/1234",
               write_en, wreg, writedata);
    end
    vectors++;
    if (busy[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL alu_busy_hold got=%b want=1", busy[3]);
    end
    tick;
    vectors++;
    if (write_en !== 1'b0 || busy[3] !== 1'b0) begin
      miscompares++;
      $display("FAIL alu_after got=%b/%b want=0/0", write_en, busy[3]);
    end
  endtask

  task automatic test_contention;
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1'b1;
      issue_reg = (i % 2 == 0) ? 3'd1 : 3'd2;
      tick;
    end
    issue_valid = 1'b0;
    alu_valid = 1'b1;
    alu_reg = 3'd1;
    alu_data = 16'hAAAA;
    ld_valid = 1'b1;
    ld_reg = 3'd2;
    ld_data = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (ld_ready !== (i % 2 == 0) || alu_ready !== (i % 2 == 1)) begin
        miscompares++;
        $display("FAIL cont_grant%0d got ld=%b alu=%b want ld=%b",
                 i, ld_ready, alu_ready, (i % 2 == 0));
      end
      if (i > 0) begin
        vectors++;
        if (write_en !== 1'b1 ||
            wreg !== ((i % 2 == 1) ? 3'd2 : 3'd1) ||
            writedata !== ((i % 2 == 1) ? 16'h5555 : 16'hAAAA)) begin
          miscompares++;
          $display("FAIL cont_write%0d got=%b/%0d/%h", i,
                   write_en, wreg, writedata);
        end
      end
      tick;
    end
    alu_valid = 1'b0;
    ld_valid = 1'b0;
    #1;
    vectors++;
    if (write_en !== 1'b1 || wreg !== 3'd1 || writedata !== 16'hAAAA) begin
      miscompares++;
      $display("FAIL cont_last got=%b/%0d/%h want=1/1/aaaa",
               write_en, wreg, writedata);
    end
    tick;
    vectors++;
    if (busy !== 8'h00 || write_en !== 1'b0) begin
      miscompares++;
      $display("FAIL cont_drain got busy=%h we=%b want=00/0",
               busy, write_en);
    end
  endtask

  task automatic test_scoreboard;
    issue_valid = 1'b1;
    issue_reg = 3'd5;
    tick;
    tick;
    tick;
    #1;
    vectors++;
    if (busy[5] !== 1'b1 || issue_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_full got busy=%b ready=%b want=1/0",
               busy[5], issue_ready);
    end
    tick;
    issue_valid = 1'b0;
    alu_valid = 1'b1;
    alu_reg = 3'd5;
    alu_data = 16'($urandom);
    tick;
    alu_valid = 1'b0;
    #1;
    vectors++;
    if (write_en !== 1'b1 || issue_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL sb_same_edge got we=%b ready=%b want=1/1",
               write_en, issue_ready);
    end
    tick;
    #1;
    vectors++;
    if (busy[5] !== 1'b1 || issue_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL sb_one_back got busy=%b ready=%b want=1/1",
               busy[5], issue_ready);
    end
    alu_valid = 1'b1;
    tick;
    tick;
    alu_valid = 1'b0;
    #1;
    vectors++;
    if (busy[5] !== 1'b1) begin
      miscompares++;
      $display("FAIL sb_two_back got=%b want=1", busy[5]);
    end
    tick;
    #1;
    vectors++;
    if (busy[5] !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_drained got=%b want=0", busy[5]);
    end
  endtask

  task automatic test_same_edge;
    issue_valid = 1'b1;
    issue_reg = 3'd4;
    tick;
    issue_valid = 1'b0;
    alu_valid = 1'b1;
    alu_reg = 3'd4;
    alu_data = 16'hBEEF;
    tick;
    alu_valid = 1'b0;
    issue_valid = 1'b1;
    tick;
    issue_valid = 1'b0;
    #1;
    vectors++;
    if (busy[4] !== 1'b1) begin
      miscompares++;
      $display("FAIL same_edge_busy got=%b want=1", busy[4]);
    end
    alu_valid = 1'b1;
    tick;
    alu_valid = 1'b0;
    tick;
    vectors++;
    if (busy[4] !== 1'b0) begin
      miscompares++;
      $display("FAIL same_edge_count got=%b want=0", busy[4]);
    end
  endtask

  task automatic test_r0;
    issue_valid = 1'b1;
    issue_reg = 3'd0;
    tick;
    issue_valid = 1'b0;
    alu_valid = 1'b1;
    alu_reg = 3'd0;
    alu_data = 16'hFFFF;
    #1;
    vectors++;
    if (alu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL r0_ready got=%b want=1", alu_ready);
    end
    tick;
    alu_valid = 1'b0;
    #1;
`ifdef WB_R0_ZERO_EN
    vectors++;
    if (write_en !== 1'b0 || busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL r0_zero got we=%b busy0=%b want=0/0",
               write_en, busy[0]);
    end
`else
    vectors++;
    if (write_en !== 1'b1 || wreg !== 3'd0 || busy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL r0_plain got we=%b wreg=%0d busy0=%b want=1/0/1",
               write_en, wreg, busy[0]);
    end
`endif
    tick;
  endtask

  task automatic test_async_reset;
    issue_valid = 1'b1;
    issue_reg = 3'd2;
    tick;
    tick;
    issue_valid = 1'b0;
    alu_valid = 1'b1;
    alu_reg = 3'd2;
    alu_data = 16'h0F0F;
    tick;
    alu_valid = 1'b0;
    #1;
    vectors++;
    if (write_en !== 1'b1 || busy[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL arst_pre got we=%b busy2=%b want=1/1",
               write_en, busy[2]);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (write_en !== 1'b0 || busy !== 8'h00) begin
      miscompares++;
      $display("FAIL arst_now got we=%b busy=%h want=0/00",
               write_en, busy);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset;
    for (int i = 0; i < 3; i++) begin
      tick;
      vectors++;
      if (write_en !== 1'b0) begin
        miscompares++;
        $display("FAIL arst_after%0d got=%b want=0", i, write_en);
      end
    end
  endtask

  task automatic test_random;
    int   avail [8];
    bit   a_act, l_act;
    int   r;
    for (int i = 0; i < 8; i++) avail[i] = 0;
    a_act = 1'b0;
    l_act = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!a_act && $urandom_range(1, 0) == 1) begin
        r = int'($urandom_range(7, 0));
        if (avail[r] > 0) begin
          avail[r]--;
          a_act = 1'b1;
          alu_reg = 3'(r);
          alu_data = 16'($urandom);
        end
      end
      if (!l_act && $urandom_range(1, 0) == 1) begin
        r = int'($urandom_range(7, 0));
        if (avail[r] > 0) begin
          avail[r]--;
          l_act = 1'b1;
          ld_reg = 3'(r);
          ld_data = 16'($urandom);
        end
      end
      alu_valid = a_act;
      ld_valid = l_act;
      issue_valid = ($urandom_range(1, 0) == 1);
      issue_reg = 3'($urandom_range(7, 0));
      #1;
      model_comb;
      vectors++;
      if (issue_ready !== e_ir) begin
        miscompares++;
        $display("FAIL rnd_issue_ready c%0d got=%b want=%b",
                 cyc, issue_ready, e_ir);
      end
      vectors++;
      if ((alu_valid && alu_ready !== e_ar) ||
          (ld_valid && ld_ready !== e_lr)) begin
        miscompares++;
        $display("FAIL rnd_grant c%0d got=%b%b want=%b%b",
                 cyc, alu_ready, ld_ready, e_ar, e_lr);
      end
      vectors++;
      if (write_en !== m_we ||
          (m_we && (wreg !== 3'(m_wr) || writedata !== 16'(m_wd)))) begin
        miscompares++;
        $display("FAIL rnd_write c%0d got=%b/%0d/%h want=%b/%0d/%h",
                 cyc, write_en, wreg, writedata, m_we, m_wr, m_wd);
      end
      vectors++;
      if (busy !== e_busy) begin
        miscompares++;
        $display("FAIL rnd_busy c%0d got=%h want=%h", cyc, busy, e_busy);
      end
      if (alu_valid && e_ar) a_act = 1'b0;
      if (ld_valid && e_lr) l_act = 1'b0;
      if (issue_valid && e_ir) avail[issue_reg]++;
      tick;
    end
    idle_inputs;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset;
    test_reset;
    test_alu_only;
    test_contention;
    test_scoreboard;
    test_same_edge;
    test_r0;
    test_async_reset;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and register scoreboard sitting directly upstream of the 8×16-bit register file. Merges results from the single-cycle ALU path and the variable-latency load path onto the register file's single write port (`write_en`/`wreg`/`writedata`), one write per cycle. Tracks outstanding writes per register so decode can stall on RAW hazards.

## Interface
Parameters:
- `DATA_W`, 16, result / register width
- `ADDR_W`, 3, register index width (8 registers)
- `CNT_W`, 2, per-register pending-write counter width

Ports:
- `clk` in 1: sole clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `issue_valid` in 1: decode issues an instruction that will write `issue_reg`
- `issue_reg` in ADDR_W: destination of issued instruction
- `issue_ready` out 1: issue accepted this cycle
- `alu_valid` in 1 / `alu_ready` out 1: ALU result handshake
- `alu_reg` in ADDR_W / `alu_data` in DATA_W: ALU destination and value
- `ld_valid` in 1 / `ld_ready` out 1: load result handshake
- `ld_reg` in ADDR_W / `ld_data` in DATA_W: load destination and value
- `write_en` out 1: to register file
- `wreg` out ADDR_W: to register file
- `writedata` out DATA_W: to register file
- `busy` out 8: bit r = register r has ≥1 pending write

## Operation
- Source transfer occurs when `valid && ready` at a rising edge. Sources must hold reg/data stable while valid and not ready.
- Arbitration, combinational from valid inputs:
  - One source valid: it is granted (`ready`=1).
  - Both valid: round-robin via `last_grant` flop; the source not granted last time wins; `last_grant` updates on every transfer.
  - Neither valid: both ready=1 (idle accept).
- Granted result is registered into output stage: `write_en`=1, `wreg`, `writedata` for exactly one cycle; no transfer -> `write_en`=0, `wreg`/`writedata` hold last values.
- Scoreboard: per-register counter `cnt[r]` of CNT_W bits.
  - Increment on issue handshake to r; decrement at edge where `write_en`=1 and `wreg`=r (edge regfile commits).
  - Same-edge increment and decrement on same r: unchanged.
  - `issue_ready` = 0 when `cnt[issue_reg]` = 2^CNT_W−1 and no same-edge decrement of that register; otherwise 1.
  - `busy[r]` = `cnt[r]` != 0, combinational from counters.
  - Write with `cnt[r]`=0 (spurious): counter stays 0; sim-only assertion fires.

## Timing
- Reset (async assert, sync release): `write_en`=0, `wreg`=0, `writedata`=0, all `cnt`=0, `busy`=0, `last_grant`=ALU (first contention goes to load). `issue_ready`/`alu_ready`/`ld_ready` follow combinational rules from reset state.
- Latency: handshake at edge N -> `write_en` high during cycle N..N+1 -> regfile commits and `busy` bit drops at edge N+1.
- Throughput: one write per cycle; under continuous contention sources alternate strictly.
- Reset mid-operation: in-flight output write dropped (`write_en` forced 0), counters cleared; no partial write reaches regfile.

## Configuration
- `WB_R0_ZERO_EN` defined: register 0 is hardwired zero. Transfers targeting r0 still handshake but produce `write_en`=0; issue to r0 never increments `cnt[0]`; `busy[0]` constant 0.
- Undefined: r0 treated like any other register.

## Structure
- Shared package `cpu_pkg`: `DATA_W`, `ADDR_W`, `NUM_REGS`=8, `wb_src_t` enum {`SRC_ALU`, `SRC_LD`}.
- One sub-module: `wb_scoreboard` (counters, `busy`, `issue_ready`); arbiter and output register in `wb_arbiter` top.

## Test plan
- Reset, ALU only: alu r3=0x1234 at edge 1 -> `write_en`=1, `wreg`=3, `writedata`=0x1234 during cycle 1–2, then `write_en`=0.
- Contention: ALU r1=0xAAAA and load r2=0x5555 both valid 4 cycles -> grants load, ALU, load, ALU; all four writes in order.
- Scoreboard: issue r5 ×3 -> `busy[5]`=1, `issue_ready`=0 on 4th issue; one write r5 -> `issue_ready`=1, `busy[5]` stays 1 until third write.
- Simultaneous issue and commit r4 with `cnt[4]`=1 -> `cnt[4]` stays 1, `busy[4]`=1.
- `WB_R0_ZERO_EN` defined: ALU write r0=0xFFFF -> `alu_ready`=1, `write_en`=0; issue r0 -> `busy[0]`=0.
- Async `rst` pulse mid-cycle with `write_en`=1 and `cnt[2]`=2 -> `write_en`, `busy` immediately 0; no write after release.
